// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM states,
// parity modes, data-length encoding and small decode helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [1:0] BITS_5 = 2'd0;
  localparam logic [1:0] BITS_6 = 2'd1;
  localparam logic [1:0] BITS_7 = 2'd2;
  localparam logic [1:0] BITS_8 = 2'd3;

  // Index of the final data bit: 4 for BITS_5 up to 7 for BITS_8.
  function automatic logic [2:0] last_bit_index(input logic [1:0] bits);
    return {1'b1, bits};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    return 8'hFF >> (BITS_8 - bits);
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLK_FREQ/BAUD cycles and strobes on the last
// cycle of each bit; held at zero while clear is high.
module uart_baud_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_reg;

  assign bit_end = !clear && (count_reg == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear || bit_end) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Configurable UART frame transmitter (5-8 data bits, none/even/odd parity,
// one or two stop bits) with a registered serial output and done pulse.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] cfg_bits,
  input  logic [1:0] cfg_parity,
  input  logic       cfg_stop2,
  output logic       uart_tx,
  output logic       tx_done,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / BAUD;

  if (DIV < 2) begin : g_div_check
    $error("uart_frame_tx: CLK_FREQ/BAUD must be at least 2");
  end

  state_t     state_reg, state_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic       ready_en_reg;
  logic [7:0] data_reg;
  logic [1:0] bits_reg;
  logic [1:0] parity_reg;
  logic       stop2_reg;
  logic       bit_end;
  logic       accept;
  logic       parity_bit;
  logic       line_next;
  logic       done_next;

  // ready_en_reg keeps tx_ready low during reset and raises it on the first edge after.
  assign tx_ready = ready_en_reg && (state_reg == ST_IDLE);
  assign busy     = !tx_ready;
  assign accept   = tx_valid && tx_ready;

  assign parity_bit = (^(data_reg & data_mask(bits_reg))) ^ (parity_reg == PAR_ODD);

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg == ST_IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      bit_idx_reg  <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_idx_reg  <= bit_idx_next;
      ready_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        bit_idx_next = '0;
        if (accept) state_next = ST_START;
      end
      ST_START: begin
        if (bit_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == last_bit_index(bits_reg)) begin
            bit_idx_next = '0;
            state_next   = parity_enabled(parity_reg) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        // bit_idx_reg counts completed stop bits.
        if (bit_end) begin
          bit_idx_next = bit_idx_reg + 3'd1;
          if (!stop2_reg || (bit_idx_reg == 3'd1)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    line_next = 1'b1;
    done_next = (state_reg == ST_STOP) && (state_next == ST_IDLE);
    case (state_next)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = data_reg[bit_idx_next];
      ST_PARITY: line_next = parity_bit;
      default:   line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      uart_tx <= line_next;
      tx_done <= done_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= '0;
      bits_reg   <= '0;
      parity_reg <= '0;
      stop2_reg  <= 1'b0;
    end else if (accept) begin
      data_reg   <= tx_data;
      bits_reg   <= cfg_bits;
      parity_reg <= cfg_parity;
      stop2_reg  <= cfg_stop2;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at DIV=10: frame shapes, lengths, done
// pulses, back-to-back timing, config capture and mid-frame reset.
module tb_uart_frame_tx;

  localparam int DIV = 10;

  logic       clk;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] cfg_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       uart_tx;
  logic       tx_done;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  uart_frame_tx #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .uart_tx    (uart_tx),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
  endtask

  // exp lists line levels per bit period in transmit order ("0" = start bit).
  task automatic send_frame(input string tag, input logic [7:0] d, input logic [1:0] b,
                            input logic [1:0] p, input logic s2, input string exp,
                            input int scramble_at);
    int len, bad, done_cnt, done_at;
    len      = exp.len() * DIV;
    bad      = 0;
    done_cnt = 0;
    done_at  = -1;
    tx_data = d; cfg_bits = b; cfg_parity = p; cfg_stop2 = s2;
    tx_valid = 1'b1;
    wait_ready(tag);
    tick;
    tx_valid = 1'b0;
    for (int c = 0; c <= len + 1; c++) begin
      if (c == scramble_at) begin
        tx_data = ~d; cfg_bits = ~b; cfg_parity = 2'd0; cfg_stop2 = ~s2;
      end
      if (c < len && uart_tx !== (exp[c / DIV] == 8'h31)) bad++;
      if (c == len / 2) check({tag, "_busy_mid"}, {30'd0, busy, tx_ready}, 32'h2);
      if (c == len) check({tag, "_ready_end"}, {30'd0, tx_ready, uart_tx}, 32'h3);
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c <= len) tick;
    end
    check({tag, "_line_bad_cycles"}, 32'(bad), 32'd0);
    check({tag, "_done_cycle"}, 32'(done_at), 32'(len));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    $display("frame %s data=%02h bits=%0d par=%0d stop2=%0d len=%0d done_at=%0d bad=%0d",
             tag, d, b, p, s2, len, done_at, bad);
  endtask

  task automatic back_to_back(input string tag, input logic [7:0] d, input logic [1:0] p,
                              input int exp_len, input int exp_gap);
    int d1, d2, s2c;
    d1 = -1; d2 = -1; s2c = -1;
    tx_data = d; cfg_bits = 2'd3; cfg_parity = p; cfg_stop2 = 1'b0;
    tx_valid = 1'b1;
    wait_ready(tag);
    tick;
    for (int c = 0; c < 3 * exp_len && d2 < 0; c++) begin
      if (tx_done === 1'b1) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      if (d1 >= 0 && s2c < 0 && c > d1 && uart_tx === 1'b0) s2c = c;
      if (d1 >= 0 && c == d1 + 1) tx_valid = 1'b0;
      tick;
    end
    tx_valid = 1'b0;
    check({tag, "_first_done"}, 32'(d1), 32'(exp_len));
    check({tag, "_start2_offset"}, 32'(s2c - d1), 32'd1);
    check({tag, "_done_gap"}, 32'(d2 - d1), 32'(exp_gap));
    $display("b2b %s data=%02h par=%0d done1=%0d start2=%0d done2=%0d", tag, d, p, d1, s2c, d2);
  endtask

  initial begin
    int dones, lows;
    reset_n = 1'b0; tx_data = '0; tx_valid = 1'b0;
    cfg_bits = '0; cfg_parity = '0; cfg_stop2 = 1'b0;

    #12;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_ready_before_edge", 32'(tx_ready), 32'd0);
    tick;
    check("rel_ready_first_edge", {30'd0, tx_ready, busy}, 32'h2);
    $display("reset release: tx_ready=%0b busy=%0b uart_tx=%0b", tx_ready, busy, uart_tx);

    send_frame("a5_8e1", 8'hA5, 2'd3, 2'd1, 1'b0, "01010010101", -1);
    send_frame("1f_5o2", 8'h1F, 2'd0, 2'd2, 1'b1, "011111011", -1);
    send_frame("80_8p3", 8'h80, 2'd3, 2'd3, 1'b0, "0000000011", -1);
    send_frame("80_8n1", 8'h80, 2'd3, 2'd0, 1'b0, "0000000011", -1);
    send_frame("ff_7e1", 8'hFF, 2'd2, 2'd1, 1'b0, "0111111111", -1);
    send_frame("c5_6o1", 8'hC5, 2'd1, 2'd2, 1'b0, "010100011", -1);
    send_frame("a5_scramble", 8'hA5, 2'd3, 2'd1, 1'b0, "01010010101", 20);

    back_to_back("3c_8n1", 8'h3C, 2'd0, 100, 101);
    back_to_back("3c_8e1", 8'h3C, 2'd1, 110, 111);

    // Mid-frame reset on an all-zero byte so the forced idle level is visible.
    tx_data = 8'h00; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    tx_valid = 1'b1;
    wait_ready("rst_mid");
    tick;
    tx_valid = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (c == 44) check("rst_mid_line_low", 32'(uart_tx), 32'd0);
      tick;
    end
    reset_n = 1'b0;
    #1;
    check("rst_mid_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_mid_flags", {29'd0, tx_done, tx_ready, busy}, 32'h1);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (tx_done === 1'b1) dones++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    check("rst_mid_ready_after", 32'(tx_ready), 32'd1);
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      if (tx_done === 1'b1) dones++;
      if (uart_tx !== 1'b1) lows++;
      tick;
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);
    check("rst_mid_line_idle", 32'(lows), 32'd0);
    $display("mid-frame reset: dones=%0d low_cycles=%0d tx_ready=%0b", dones, lows, tx_ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
